// File: rtl/bit32_div_pkg.sv
// Shared definitions for the sequential 32-bit MIPS divider.
package bit32_div_pkg;

    localparam int          WIDTH     = 32;
    localparam int          LAST_ITER = 31;
    localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bit32_seq_div_if.sv
// Launch/result bundle between the EX stage and the divider.
interface bit32_seq_div_if import bit32_div_pkg::*; ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/bit32_negate.sv
// Two's-complement negation: inverter followed by an incrementer.
module bit32_negate (
    input  logic [31:0] a,
    output logic [31:0] y
);

    logic [31:0] a_inv;

    bit32_not u_not (
        .a (a),
        .y (a_inv)
    );

    assign y = a_inv + 32'd1;

endmodule

// File: rtl/bit32_not.sv
// Bitwise inverter shared with the ALU datapath.
module bit32_not (
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = ~a;

endmodule

// File: rtl/bit32_seq_div.sv
// Restoring shift-subtract divider for DIV/DIVU: LO = quotient, HI = remainder.
// Fixed latency: LOAD (1) + CALC (32) + DONE (1) after the accepting edge.
module bit32_seq_div import bit32_div_pkg::*; #(
    parameter int WIDTH = bit32_div_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    bit32_seq_div_if.slave bus
);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r, dbz;
    logic [WIDTH-1:0] dvd_raw, dvsr_mag, q_r, rem_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             div_by_zero_r;

    logic [WIDTH-1:0] dvd_neg, dvs_neg, dvd_mag, dvs_mag;
    logic [WIDTH-1:0] dvsr_inv, q_nxt, rem_nxt, q_neg, rem_neg;
    logic [WIDTH:0]   partial, trial;
    logic             accept, last_iter;

    // Operand magnitudes taken straight off the ports during LOAD
    bit32_negate u_neg_dvd (.a(bus.dividend), .y(dvd_neg));
    bit32_negate u_neg_dvs (.a(bus.divisor),  .y(dvs_neg));

    assign dvd_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? dvd_neg : bus.dividend;
    assign dvs_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? dvs_neg : bus.divisor;

    // Trial subtract: partial + ~divisor + 1. The partial remainder is
    // 33 bits because the bit shifted out of rem still counts; bit 32 of
    // the trial is then the borrow, so a clear bit means partial >= divisor.
    bit32_not u_not_dvs (.a(dvsr_mag), .y(dvsr_inv));

    assign partial   = {rem_r, q_r[WIDTH-1]};
    assign trial     = partial + {1'b1, dvsr_inv} + {{WIDTH{1'b0}}, 1'b1};
    assign accept    = ~trial[WIDTH];
    assign rem_nxt   = accept ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    assign q_nxt     = {q_r[WIDTH-2:0], accept};
    assign last_iter = (cnt == CNT_W'(LAST_ITER));

    // Sign fix-up works on the final iteration's values so results land
    // in the same edge that enters DONE
    bit32_negate u_neg_q (.a(q_nxt),   .y(q_neg));
    bit32_negate u_neg_r (.a(rem_nxt), .y(rem_neg));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode
    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.busy  = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
                state_nxt = bus.start ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dbz           <= 1'b0;
            dvd_raw       <= '0;
            dvsr_mag      <= '0;
            q_r           <= '0;
            rem_r         <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    sign_q   <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    sign_r   <= bus.is_signed & bus.dividend[WIDTH-1];
                    dbz      <= (bus.divisor == '0);
                    dvd_raw  <= bus.dividend;
                    dvsr_mag <= dvs_mag;
                    q_r      <= dvd_mag;
                    rem_r    <= '0;
                    cnt      <= '0;
                end
                CALC: begin
                    q_r   <= q_nxt;
                    rem_r <= rem_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient_r    <= dbz ? DIVZERO_Q : (sign_q ? q_neg : q_nxt);
                        remainder_r   <= dbz ? dvd_raw   : (sign_r ? rem_neg : rem_nxt);
                        div_by_zero_r <= dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_bit32_seq_div.sv
// Directed bench for bit32_seq_div: results, latency, back-to-back, reset abort.
module tb_bit32_seq_div;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat, bsy;

    bit32_seq_div_if bus ();

    bit32_seq_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raise start at a negedge, drop it one cycle later (now in LOAD, cycle 1)
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle index of the done pulse and the
    // number of busy cycles before it. poke fires ignored starts in cycles 5-20.
    task automatic wait_done(input bit poke, output int l, output int b);
        b = 0;
        for (l = 1; l <= 60; l++) begin
            if (bus.done) break;
            if (bus.busy) b++;
            if (poke) begin
                if (l >= 5 && l <= 20) begin
                    bus.start     = l[0];
                    bus.is_signed = 1'b1;
                    bus.dividend  = 32'd5;
                    bus.divisor   = 32'd1;
                end else begin
                    bus.start = 1'b0;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic edz);
        int l, bc;
        launch(sgn, a, b);
        wait_done(1'b0, l, bc);
        chk({tag, "_lat"}, l, 34);
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
        chk({tag, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_q",     bus.quotient,  32'd0);
        chk("rst_r",     bus.remainder, 32'd0);
        chk("rst_dz",    {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // DIVU 100/7 with latency and busy-window checks
        launch(1'b0, 32'd100, 32'd7);
        chk("u100_ld_busy",  {31'd0, bus.busy},  32'd1);
        chk("u100_ld_ready", {31'd0, bus.ready}, 32'd0);
        wait_done(1'b0, lat, bsy);
        chk("u100_lat",  lat, 34);
        chk("u100_busy", bsy, 33);
        chk("u100_dn_busy", {31'd0, bus.busy}, 32'd0);
        chk("u100_q", bus.quotient,  32'd14);
        chk("u100_r", bus.remainder, 32'd2);
        chk("u100_dz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        chk("u100_pulse", {31'd0, bus.done}, 32'd0);
        chk("u100_hold",  bus.quotient, 32'd14);

        run_div("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("s_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        run_div("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        run_div("u_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run_div("u_bigd",  1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0);
        run_div("u_dbz",   1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_div("u_clrdz", 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);

        // Ignored starts mid-operation, then back-to-back launch from DONE
        launch(1'b0, 32'd1000, 32'd10);
        wait_done(1'b1, lat, bsy);
        chk("ign_lat", lat, 34);
        chk("ign_q", bus.quotient,  32'd100);
        chk("ign_r", bus.remainder, 32'd0);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'hFFFF_FFFF;
        bus.divisor   = 32'd16;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_ld_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(1'b0, lat, bsy);
        chk("b2b_lat", lat, 34);
        chk("b2b_q", bus.quotient,  32'h0FFF_FFFF);
        chk("b2b_r", bus.remainder, 32'd15);

        // Asynchronous reset in cycle 10 of an operation
        launch(1'b0, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, bus.busy},  32'd0);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_q", bus.quotient,  32'd0);
        chk("abort_r", bus.remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_div("u_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
